truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Sequential self-checking exerciser for small combinational logic blocks. It walks every input vector of an N_IN-input block under test in ascending binary order and holds each vector for a programmable settle time. It samples the block's single output and compares it against a parameterised expected truth table, then reports a per-vector mismatch mask, a mismatch count and a pass/done handshake. It is the hardware counterpart of the exhaustive stimulus/monitor benches used for our gate-level circuits, so checks can run on-chip or in long regressions.

## Interface
- N_IN, default 3: number of inputs of the block under test; 1..6.
- SETTLE, default 2: cycles each vector is held before sampling; ≥1.
- EXPECTED, default 8'h96: expected output, bit k = output for input vector k; width 2**N_IN.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request, sampled on rising clk.
- abort  input  1  cancel a run in progress.
- dut_in  output  N_IN  vector driven to block under test; dut_in[N_IN-1] is the MSB.
- dut_out  input  1  output of block under test.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  last completed run had zero mismatches.
- fail_mask  output  2**N_IN  bit k set if vector k mismatched.
- fail_count  output  N_IN+1  number of mismatching vectors.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, immediate): state IDLE, dut_in=0, busy=0, done=0, pass=0, fail_mask=0, fail_count=0, settle counter=0.
- IDLE: start=1 → RUN. On that edge: dut_in=0, settle counter=0, fail_mask=0, fail_count=0, pass=0, busy=1.
- RUN:
  - The settle counter counts 0..SETTLE-1.
  - On the edge where the counter equals SETTLE-1, dut_out is sampled for the current vector k=dut_in.
  - If dut_out != EXPECTED[k], set fail_mask[k] and increment fail_count.
  - On the same edge the counter wraps to 0 and dut_in increments.
  - If k = 2**N_IN-1, dut_in wraps to 0 and the state moves to DONE.
- DONE: lasts exactly one cycle.
  - done=1, busy=0.
  - pass=1 iff the final fail_count=0. pass takes its value on the edge entering DONE, so the final vector's result is included.
  - Next edge → IDLE, or directly back to RUN if start=1, with the same initialisation as from IDLE.
- Holding results: fail_mask, fail_count and pass hold after DONE until the next accepted start or rst.
- abort=1 in RUN: next edge → IDLE.
  - dut_in=0, busy=0.
  - done stays 0 and pass stays 0.
  - The partial fail_mask/fail_count are held for debug.
- abort has priority over a sample on the same edge; that sample is discarded. abort in IDLE or DONE has no effect.
- start while in RUN is ignored.
- fail_count arithmetic is unsigned and never saturates; maximum 2**N_IN fits in N_IN+1 bits.

## Timing
- Start accepted at edge E0. Vector k is driven from E0+k·SETTLE and sampled at edge E0+(k+1)·SETTLE.
- The final sample is at E0+2**N_IN·SETTLE. done is high for the cycle following that edge.
- Default run (N_IN=3, SETTLE=2): 16 cycles busy; done during cycle 17 after E0.
- busy deasserts on the same edge that asserts done.
- dut_out is treated as combinational from dut_in. It must be stable within SETTLE cycles; no synchroniser is present.
- rst mid-run: all outputs return to reset values immediately, asynchronously; the checker waits in IDLE for a new start.

## Test plan
- Correct DUT model (out = EXPECTED[dut_in]), defaults, start pulse → busy 16 cycles; dut_in steps 0..7 every 2 cycles; done pulse 1 cycle; pass=1, fail_mask=8'h00, fail_count=0.
- DUT output stuck at 0 → pass=0, fail_mask=8'h96, fail_count=4.
- Inverted DUT output → fail_mask=8'hFF, fail_count=8, pass=0. Then start asserted during DONE → run restarts with no IDLE cycle and mask cleared to 0 on that edge.
- abort asserted at the sample edge of vector 3 with a stuck-at-0 DUT → next cycle IDLE, dut_in=0, done never asserts, fail_mask=8'h06, fail_count=2. A vector-3 mismatch would not be recorded anyway, since EXPECTED[3]=0 and the DUT outputs 0.
- start held high during RUN → no restart, completion timing unchanged. rst pulsed mid-run at vector 5 → outputs zero immediately and no done pulse.
- SETTLE=1, N_IN=2, EXPECTED=4'hA, correct model → busy 4 cycles, done on the 5th, pass=1.

Source files
------------

// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustively steps an N_IN-input block and compares its output to EXPECTED
module truth_table_checker #(
    parameter int                  N_IN     = 3,
    parameter int                  SETTLE   = 2,
    parameter logic [2**N_IN-1:0]  EXPECTED = 8'h96
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [N_IN-1:0]     dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2**N_IN-1:0]  fail_mask,
    output logic [N_IN:0]       fail_count
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [2**N_IN-1:0] mask_q, mask_d;
    logic [N_IN:0]      count_q, count_d, count_inc;
    logic               pass_q, pass_d;
    logic               miss, last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        count_d   = count_q;
        pass_d    = pass_q;
        miss      = dut_out != EXPECTED[vec_q];
        last      = cnt_q == SW'(SETTLE - 1);
        count_inc = count_q + {{N_IN{1'b0}}, miss};
        case (state_q)
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else if (last) begin
                    cnt_d   = '0;
                    vec_d   = vec_q + 1'b1;
                    count_d = count_inc;
                    if (miss)
                        mask_d[vec_q] = 1'b1;
                    if (&vec_q) begin
                        state_d = DONE;
                        pass_d  = count_inc == '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase
        // IDLE and DONE both accept a new run with identical initialisation
        if (state_q != RUN && start) begin
            state_d = RUN;
            vec_d   = '0;
            cnt_d   = '0;
            mask_d  = '0;
            count_d = '0;
            pass_d  = 1'b0;
        end
    end

    assign dut_in     = vec_q;
    assign busy       = state_q == RUN;
    assign done       = state_q == DONE;
    assign pass       = pass_q;
    assign fail_mask  = mask_q;
    assign fail_count = count_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed checks of truth_table_checker with a modelled block under test
module tb_truth_table_checker;
    logic       clk, rst, start, abort;
    logic [2:0] dut_in;
    logic       dut_out, busy, done, pass;
    logic [7:0] fail_mask;
    logic [3:0] fail_count;
    logic [1:0] mode;
    logic [7:0] exp_tt;

    logic       start2;
    logic [1:0] dut_in2;
    logic       dut_out2, busy2, done2, pass2;
    logic [3:0] fail_mask2;
    logic [2:0] fail_count2;
    logic [3:0] exp_tt2;

    int n_cmp = 0;
    int n_bad = 0;

    truth_table_checker dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
        .pass(pass), .fail_mask(fail_mask), .fail_count(fail_count)
    );

    truth_table_checker #(.N_IN(2), .SETTLE(1), .EXPECTED(4'hA)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
        .pass(pass2), .fail_mask(fail_mask2), .fail_count(fail_count2)
    );

    // mode 0: correct block, 1: stuck-at-0, 2: inverted
    assign dut_out  = mode == 2'd0 ? exp_tt[dut_in] : mode == 2'd1 ? 1'b0 : ~exp_tt[dut_in];
    assign dut_out2 = exp_tt2[dut_in2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic do_run(input logic [1:0] m, input bit hold, input logic [7:0] emask,
                          input logic [3:0] ecnt, input logic epass);
        mode  = m;
        start = 1'b1;
        tick();
        if (!hold)
            start = 1'b0;
        chk("init_mask", fail_mask, 0);
        chk("init_count", fail_count, 0);
        chk("init_pass", pass, 0);
        for (int j = 0; j < 16; j++) begin
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_vec", dut_in, j / 2);
            if (j == 15)
                start = 1'b0;
            tick();
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_vec", dut_in, 0);
        chk("end_pass", pass, epass);
        chk("end_mask", fail_mask, emask);
        chk("end_count", fail_count, ecnt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        mode = 2'd0; exp_tt = 8'h96; exp_tt2 = 4'hA;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_mask", fail_mask, 0);
        chk("rst_count", fail_count, 0);
        chk("rst_vec", dut_in, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        do_run(2'd0, 1'b0, 8'h00, 4'd0, 1'b1);
        tick();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("hold_pass", pass, 1);

        do_run(2'd1, 1'b0, 8'h96, 4'd4, 1'b0);
        tick();
        chk("hold_mask", fail_mask, 8'h96);

        // second run starts from the DONE cycle of the first
        do_run(2'd2, 1'b0, 8'hFF, 4'd8, 1'b0);
        do_run(2'd0, 1'b0, 8'h00, 4'd0, 1'b1);
        tick();

        // abort on the sample edge of vector 3
        mode  = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("pre_abort_vec", dut_in, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_vec", dut_in, 0);
        chk("abort_mask", fail_mask, 8'h06);
        chk("abort_count", fail_count, 2);
        for (int j = 0; j < 12; j++) begin
            chk("abort_done", done, 0);
            chk("abort_pass", pass, 0);
            tick();
        end

        do_run(2'd0, 1'b1, 8'h00, 4'd0, 1'b1);
        tick();
        chk("held_start_idle", busy, 0);

        // asynchronous reset at vector 5
        mode  = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("pre_rst_vec", dut_in, 5);
        chk("pre_rst_count", fail_count, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_vec", dut_in, 0);
        chk("arst_mask", fail_mask, 0);
        chk("arst_count", fail_count, 0);
        #1 rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("arst_idle_busy", busy, 0);
            chk("arst_idle_done", done, 0);
        end

        // N_IN=2, SETTLE=1 instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("s1_busy", busy2, 1);
            chk("s1_vec", dut_in2, j);
            chk("s1_done", done2, 0);
            tick();
        end
        chk("s1_end_done", done2, 1);
        chk("s1_end_busy", busy2, 0);
        chk("s1_pass", pass2, 1);
        chk("s1_mask", fail_mask2, 0);
        chk("s1_count", fail_count2, 0);
        tick();
        chk("s1_post_done", done2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
